axi_req_flit_packer: RTL
========================

Name: axi_req_flit_packer

Overview:
- Packs a one-flit-per-cycle request stream into FPW-flit AXI-Stream beats carrying the standard TUSER flag layout: valid flags, header flags, tail flags.
- Sits between the request flit source and the AXI request channel.
- Buffers up to DEPTH beats.
- Optionally flushes partial beats on packet tail or after an idle timeout.
- Checks header/tail framing.

Parameters:
- FPW, 2, flits per AXI beat (1..8).
- FLIT_W, 128, bits per flit.
- DEPTH, 4, beat FIFO depth (power of 2, >=2).
- FLUSH_ON_TAIL, 1, 1 = close the beat immediately when a tail flit is accepted.
- TIMEOUT, 16, idle cycles before a partial beat is flushed; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input flit valid.
- in_ready  out  1  input flit accepted when in_valid && in_ready.
- in_flit  in  FLIT_W  flit data.
- in_hdr  in  1  flit is a packet header.
- in_tail  in  1  flit is a packet tail.
- TVALID  out  1  AXI beat valid.
- TREADY  in  1  AXI sink ready.
- TDATA  out  FPW*FLIT_W  beat data; slot i = TDATA[i*FLIT_W +: FLIT_W].
- TUSER  out  FPW*16  valid flags [FPW-1:0], header flags [2FPW-1:FPW], tail flags [3FPW-1:2FPW]; remaining bits 0.
- fifo_level  out  $clog2(DEPTH+1)  beats held in the FIFO.
- err_proto  out  1  sticky framing error.

Behaviour:
- Reset (async, rst=1) values:
  - TVALID=0, fifo_level=0, err_proto=0, TDATA=0, TUSER=0.
  - Assembly slot index s=0, idle counter=0, in_pkt=0.
  - in_ready=0 while rst=1.
- Reset mid-operation discards the partial beat and all FIFO contents.
- in_ready = !rst && (fifo_level < DEPTH). It is registered-state derived; no combinational path from TREADY.
- Accept:
  - Flit goes to assembly slot s: data, plus valid[s]=1, hdr[s]=in_hdr, tail[s]=in_tail.
  - Then s <= s+1, and the idle counter clears.
- Beat close: the assembly register is pushed to the FIFO in the same cycle, then cleared (data and flags 0, s=0) when any of:
  - (a) a flit is accepted into slot FPW-1;
  - (b) FLUSH_ON_TAIL=1 and the accepted flit has in_tail=1;
  - (c) timeout fires.
- Unused slots of a partial beat carry data 0 and flags 0.
- Timeout:
  - Idle counter increments each cycle with s>0 and no accept.
  - It fires when counter==TIMEOUT and fifo_level<DEPTH.
  - If the FIFO is full, the flush is deferred until space frees; the counter saturates at TIMEOUT.
  - Accept and timeout expiry in the same cycle: the accept wins, the flit joins the beat, and the counter clears.
- FIFO:
  - DEPTH entries of {TDATA,TUSER}.
  - TVALID = fifo_level>0; TDATA/TUSER always show the head entry.
  - Pop on TVALID && TREADY.
  - Push and pop in the same cycle: level unchanged.
  - Head data held stable while TVALID && !TREADY.
  - Pointers wrap modulo DEPTH.
- Latency: a beat closed in cycle n is visible with TVALID=1 in cycle n+1 (if it is at the head).
- Framing (tracked by in_pkt):
  - Accepted flit with in_hdr=1 while in_pkt=1, or in_hdr=0 while in_pkt=0, sets err_proto (sticky until rst).
  - in_pkt <= 1 on an accepted header, and <= 0 on an accepted tail.
  - hdr and tail on the same flit is a legal single-flit packet; in_pkt stays 0.
  - Flits are still packed normally on error.
- Every FIFO entry has at least one valid flag set. Valid flags in an entry are contiguous from slot 0.

Test Plan:
- Reset release, FPW=2: drive 4 flits (hdr on flit 0, tail on flit 3) back-to-back, TREADY=1.
  -> 2 beats, each TUSER[1:0]=2'b11; first beat hdr=2'b01 tail=2'b00, second beat hdr=2'b00 tail=2'b10; first TVALID one cycle after flit 1 is accepted.
- FLUSH_ON_TAIL=1: single flit with hdr=tail=1.
  -> next cycle one beat, valid=2'b01, hdr=2'b01, tail=2'b01, slot 1 data 0.
- TIMEOUT=16: one header flit, then idle.
  -> beat emitted 17 cycles after accept, valid=2'b01; with a second flit at idle cycle 10, a full beat is emitted and no timeout flush occurs.
- Backpressure, TREADY=0, DEPTH=4: stream 10 two-flit packets.
  -> fifo_level reaches 4, in_ready=0, TDATA/TUSER stable; TREADY=1 then drains all 10 beats in order with no loss.
- Framing error: accept two headers without a tail.
  -> err_proto=1 on the cycle after the second accept; it stays 1 until rst.
- Assert rst mid-stream with 3 beats queued.
  -> TVALID=0, fifo_level=0, in_ready=0 immediately; after release, the first new packet is packed from slot 0.

Source files
------------

// File: rtl/axi_req_flit_packer.sv
// ---------------------------------------------------------------------------
// axi_req_flit_packer
//
// Packs a one-flit-per-cycle request stream into FPW-flit AXI-Stream beats.
// Flits collect in an assembly register slot by slot. A beat closes into a
// DEPTH-entry FIFO in these cases:
//   - the last slot fills;
//   - a tail flit arrives (when FLUSH_ON_TAIL is set);
//   - a partial beat has sat idle for TIMEOUT cycles.
// Header/tail framing is checked on every accepted flit.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   in_valid      input flit valid
//   in_ready      input flit accepted when in_valid && in_ready
//   in_flit       flit data (FLIT_W bits)
//   in_hdr        flit is a packet header
//   in_tail       flit is a packet tail
//   TVALID        AXI beat valid (FIFO not empty)
//   TREADY        AXI sink ready
//   TDATA         beat data, slot i at [i*FLIT_W +: FLIT_W]
//   TUSER         {tail flags, header flags, valid flags}, upper bits zero
//   fifo_level    beats held in the FIFO
//   err_proto     sticky framing error
// ---------------------------------------------------------------------------
module axi_req_flit_packer #(
    parameter int FPW           = 2,
    parameter int FLIT_W        = 128,
    parameter int DEPTH         = 4,
    parameter int FLUSH_ON_TAIL = 1,
    parameter int TIMEOUT       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [FLIT_W-1:0]            in_flit,
    input  logic                         in_hdr,
    input  logic                         in_tail,
    output logic                         TVALID,
    input  logic                         TREADY,
    output logic [FPW*FLIT_W-1:0]        TDATA,
    output logic [FPW*16-1:0]            TUSER,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic                         err_proto
);

    localparam int DATA_W  = FPW * FLIT_W;
    localparam int FLAG_W  = 3 * FPW;
    localparam int ENTRY_W = DATA_W + FLAG_W;
    localparam int LVL_W   = $clog2(DEPTH + 1);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int SLOT_W  = (FPW > 1) ? $clog2(FPW) : 1;
    localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [LVL_W-1:0]  DEPTH_LVL = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TIMEOUT);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FPW - 1);

    // Assembly register
    logic [DATA_W-1:0] asm_data_q, asm_data_d;
    logic [FPW-1:0]    asm_vld_q,  asm_vld_d;
    logic [FPW-1:0]    asm_hdr_q,  asm_hdr_d;
    logic [FPW-1:0]    asm_tail_q, asm_tail_d;
    logic [SLOT_W-1:0] slot_q,     slot_d;
    logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;

    // Framing state
    logic              in_pkt_q, in_pkt_d;
    logic              err_q,    err_d;

    // FIFO state
    logic [LVL_W-1:0]  level_q,  level_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ENTRY_W-1:0] mem [DEPTH];

    // Assembly register with the current flit merged into its slot
    logic [DATA_W-1:0] merged_data;
    logic [FPW-1:0]    merged_vld;
    logic [FPW-1:0]    merged_hdr;
    logic [FPW-1:0]    merged_tail;

    logic accept;
    logic has_partial;
    logic close_full;
    logic close_tail;
    logic timeout_fire;
    logic push;
    logic pop;
    logic frame_err;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;

    // in_ready depends only on registered state and rst, never on TREADY.
    assign in_ready    = !rst && (level_q < DEPTH_LVL);
    assign accept      = in_valid && in_ready;
    // Slot 0 always fills first, so its valid flag marks a partial beat.
    assign has_partial = asm_vld_q[0];

    genvar gi;
    generate
        for (gi = 0; gi < FPW; gi++) begin : g_slot
            logic hit;
            assign hit = accept && (slot_q == SLOT_W'(gi));
            assign merged_data[gi*FLIT_W +: FLIT_W] = hit ? in_flit
                                                          : asm_data_q[gi*FLIT_W +: FLIT_W];
            assign merged_vld[gi]  = hit | asm_vld_q[gi];
            assign merged_hdr[gi]  = hit ? in_hdr  : asm_hdr_q[gi];
            assign merged_tail[gi] = hit ? in_tail : asm_tail_q[gi];
        end
    endgenerate

    assign close_full = accept && (slot_q == LAST_SLOT);
    assign close_tail = accept && (FLUSH_ON_TAIL != 0) && in_tail;
    // An accept in the same cycle suppresses the timeout flush; the flit
    // joins the beat and the idle counter restarts. A full FIFO defers the
    // flush while the counter sits saturated at TIMEOUT.
    assign timeout_fire = (TIMEOUT != 0) && !accept && has_partial &&
                          (idle_cnt_q == CNT_MAX) && (level_q < DEPTH_LVL);
    // Pushes only happen while the FIFO has room: accepts need in_ready and
    // the timeout checks the level itself.
    assign push = close_full || close_tail || timeout_fire;
    assign pop  = TVALID && TREADY;

    assign frame_err  = in_hdr ? in_pkt_q : !in_pkt_q;
    assign push_entry = {merged_tail, merged_hdr, merged_vld, merged_data};

    always_comb begin
        asm_data_d = asm_data_q;
        asm_vld_d  = asm_vld_q;
        asm_hdr_d  = asm_hdr_q;
        asm_tail_d = asm_tail_q;
        slot_d     = slot_q;
        idle_cnt_d = idle_cnt_q;
        in_pkt_d   = in_pkt_q;
        err_d      = err_q;
        level_d    = level_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (push) begin
            asm_data_d = '0;
            asm_vld_d  = '0;
            asm_hdr_d  = '0;
            asm_tail_d = '0;
            slot_d     = '0;
        end else if (accept) begin
            asm_data_d = merged_data;
            asm_vld_d  = merged_vld;
            asm_hdr_d  = merged_hdr;
            asm_tail_d = merged_tail;
            slot_d     = slot_q + SLOT_W'(1);
        end

        if (accept || push) begin
            idle_cnt_d = '0;
        end else if (has_partial && (idle_cnt_q != CNT_MAX)) begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end

        if (accept) begin
            if (frame_err) begin
                err_d = 1'b1;
            end
            // A flit that is both header and tail leaves the packet closed.
            if (in_tail) begin
                in_pkt_d = 1'b0;
            end else if (in_hdr) begin
                in_pkt_d = 1'b1;
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_data_q <= '0;
            asm_vld_q  <= '0;
            asm_hdr_q  <= '0;
            asm_tail_q <= '0;
            slot_q     <= '0;
            idle_cnt_q <= '0;
            in_pkt_q   <= 1'b0;
            err_q      <= 1'b0;
            level_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            asm_data_q <= asm_data_d;
            asm_vld_q  <= asm_vld_d;
            asm_hdr_q  <= asm_hdr_d;
            asm_tail_q <= asm_tail_d;
            slot_q     <= slot_d;
            idle_cnt_q <= idle_cnt_d;
            in_pkt_q   <= in_pkt_d;
            err_q      <= err_d;
            level_q    <= level_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage carries no reset; stale entries are never visible because the
    // outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_entry;
        end
    end

    // The head slot is only rewritten after it has been popped, so the output
    // holds steady under backpressure.
    assign head_entry = mem[rd_ptr_q];
    assign TVALID     = (level_q != '0);
    assign fifo_level = level_q;
    assign err_proto  = err_q;

    always_comb begin
        TDATA = '0;
        TUSER = '0;
        if (TVALID) begin
            TDATA              = head_entry[DATA_W-1:0];
            TUSER[FLAG_W-1:0]  = head_entry[ENTRY_W-1:DATA_W];
        end
    end

endmodule
